// File: rtl/srv6_pkg.sv
// Shared types and constants for the SRv6 ingress arbiter: FSM states,
// beat geometry and the packet-length-to-beat-count helper.
package srv6_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    GAP     = 2'd2
  } state_e;

  localparam int DATA_W     = 512;
  localparam int BEAT_BYTES = 64;
  localparam int PLEN_MSB   = 479;
  localparam int PLEN_LSB   = 464;

  // A zero-length header still occupies one beat on the datapath.
  function automatic logic [16:0] beats_of(input logic [15:0] plen);
    logic [16:0] sum;
    sum = {1'b0, plen} + 17'(BEAT_BYTES - 1);
    if (plen == 16'd0) begin
      return 17'd1;
    end
    return sum >> $clog2(BEAT_BYTES);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_PORTS, returned both one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IW-1:0]        idx,
  output logic                 any
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Walk from the far end so the candidate closest to ptr is written last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_PORTS)) begin
        sum = sum - (IW+1)'(NUM_PORTS);
      end
      cand = sum[IW-1:0];
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
        gnt = {{(NUM_PORTS-1){1'b0}}, 1'b1} << cand;
      end
    end
  end

endmodule

// File: rtl/srv6_ingress_arbiter.sv
// Packet-granular round-robin arbiter feeding the single SRv6 datapath,
// with beat-count tracking, truncation, underrun detection and a quiet gap.
module srv6_ingress_arbiter
  import srv6_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int GAP_CYCLES = 16,
  parameter int MAX_BEATS  = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic [DATA_W-1:0]           dout,
  output logic                        valid,
  output logic [NUM_PORTS-1:0]        grant,
  output logic                        busy,
  output logic                        underrun,
  output logic                        truncated
);

  localparam int IW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_BEATS + 1);

  state_e                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          port_q, port_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [CW-1:0]          beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]          beats_total_q, beats_total_d;
  logic [7:0]             gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   valid_q, valid_d;
  logic                   underrun_q, underrun_d;
  logic                   truncated_q, truncated_d;

  logic [DATA_W-1:0]      port_data [NUM_PORTS];
  logic [DATA_W-1:0]      sel_data;
  logic                   sel_valid;
  logic [NUM_PORTS-1:0]   arb_gnt;
  logic [IW-1:0]          arb_idx;
  logic                   arb_any;
  logic [16:0]            raw_beats;
  logic                   over_max;
  logic [CW-1:0]          total;
  logic [CW-1:0]          cnt_inc;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port_slice
    assign port_data[gi] = in_data[gi*DATA_W +: DATA_W];
  end

  assign sel_data  = port_data[port_q];
  assign sel_valid = in_valid[port_q];

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req (in_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    port_d        = port_q;
    grant_d       = grant_q;
    beat_cnt_d    = beat_cnt_q;
    beats_total_d = beats_total_q;
    gap_cnt_d     = gap_cnt_q;
    dout_d        = dout_q;
    valid_d       = 1'b0;
    underrun_d    = 1'b0;
    truncated_d   = 1'b0;
    raw_beats     = beats_of(sel_data[PLEN_MSB:PLEN_LSB]);
    over_max      = raw_beats > 17'(MAX_BEATS);
    cnt_inc       = beat_cnt_q + 1'b1;
    total         = beats_total_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d    = arb_gnt;
          port_d     = arb_idx;
          rr_ptr_d   = (arb_idx == IW'(NUM_PORTS - 1)) ? '0 : arb_idx + 1'b1;
          beat_cnt_d = '0;
          state_d    = FORWARD;
        end
      end
      FORWARD: begin
        // The packet length is only meaningful on the header beat.
        if (beat_cnt_q == '0) begin
          total = over_max ? CW'(MAX_BEATS) : CW'(raw_beats);
        end
        if (sel_valid) begin
          valid_d       = 1'b1;
          dout_d        = sel_data;
          beat_cnt_d    = cnt_inc;
          beats_total_d = total;
          truncated_d   = (beat_cnt_q == '0) && over_max;
          if (cnt_inc == total) begin
            state_d   = GAP;
            grant_d   = '0;
            gap_cnt_d = '0;
          end
        end else if (beat_cnt_q != '0) begin
          underrun_d = 1'b1;
          state_d    = GAP;
          grant_d    = '0;
          gap_cnt_d  = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q == 8'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      port_q        <= '0;
      grant_q       <= '0;
      beat_cnt_q    <= '0;
      beats_total_q <= '0;
      gap_cnt_q     <= '0;
      dout_q        <= '0;
      valid_q       <= 1'b0;
      underrun_q    <= 1'b0;
      truncated_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      port_q        <= port_d;
      grant_q       <= grant_d;
      beat_cnt_q    <= beat_cnt_d;
      beats_total_q <= beats_total_d;
      gap_cnt_q     <= gap_cnt_d;
      dout_q        <= dout_d;
      valid_q       <= valid_d;
      underrun_q    <= underrun_d;
      truncated_q   <= truncated_d;
    end
  end

  assign in_ready  = (state_q == FORWARD) ? grant_q : '0;
  assign dout      = dout_q;
  assign valid     = valid_q;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign underrun  = underrun_q;
  assign truncated = truncated_q;

endmodule

// File: tb/tb_srv6_ingress_arbiter.sv
// Scoreboard bench: a packet-level timing model predicts every output beat
// and per-cycle control values; a monitor compares them against the DUT.
module tb_srv6_ingress_arbiter;

  localparam int NP   = 4;
  localparam int GAP  = 16;
  localparam int MAXB = 24;
  localparam int DW   = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_valid;
  logic [NP-1:0]     in_ready;
  logic [DW-1:0]     dout;
  logic              valid;
  logic [NP-1:0]     grant;
  logic              busy;
  logic              underrun;
  logic              truncated;

  srv6_ingress_arbiter #(.NUM_PORTS(NP), .GAP_CYCLES(GAP), .MAX_BEATS(MAXB)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .valid     (valid),
    .grant     (grant),
    .busy      (busy),
    .underrun  (underrun),
    .truncated (truncated)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } beat_exp_t;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  beat_exp_t     exp_q[$];
  logic [DW-1:0] beat_store[$];
  int            pk_supply[$];
  int            pk_base[$];
  bit            pk_drop[$];
  bit            pk_trunc[$];

  int port_q[NP][$];
  int m_pend[NP][$];
  int bidx[NP];
  bit hold[NP];
  int m_ptr  = 0;
  int m_free = 0;

  logic [NP-1:0] e_grant[int];
  bit            e_busy[int];
  bit            e_trunc[int];
  bit            e_under[int];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  // Queue a packet on port p; drop_k in 1..n-1 makes the source stop after drop_k beats.
  task automatic add_pkt(input int p, input logic [15:0] plen, input int drop_k);
    int n_raw, n, supply, id;
    logic [DW-1:0] d;
    n_raw  = (plen == 16'd0) ? 1 : (int'(plen) + 63) / 64;
    n      = (n_raw > MAXB) ? MAXB : n_raw;
    supply = (drop_k > 0 && drop_k < n) ? drop_k : n;
    id     = pk_supply.size();
    pk_base.push_back(beat_store.size());
    pk_supply.push_back(supply);
    pk_drop.push_back(drop_k > 0 && drop_k < n);
    pk_trunc.push_back(n_raw > MAXB);
    for (int j = 0; j < supply; j++) begin
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
      if (j == 0) d[479:464] = plen;
      beat_store.push_back(d);
    end
    port_q[p].push_back(id);
    m_pend[p].push_back(id);
  endtask

  function automatic int pend_total();
    int t = 0;
    for (int p = 0; p < NP; p++) t += m_pend[p].size();
    return t;
  endfunction

  // Packet-level timing: arbitrate, forward s beats, hold the gap, re-arbitrate.
  task automatic run_model();
    int a, w, q, id, s, last_g, nxt;
    a = (cyc + 2 > m_free) ? cyc + 2 : m_free;
    while (pend_total() > 0) begin
      w = -1;
      for (int i = 0; i < NP; i++) begin
        q = (m_ptr + i) % NP;
        if (w < 0 && m_pend[q].size() > 0) w = q;
      end
      id = m_pend[w].pop_front();
      s  = pk_supply[id];
      for (int j = 0; j < s; j++) exp_q.push_back('{a + 1 + j, beat_store[pk_base[id] + j]});
      if (pk_trunc[id]) e_trunc[a + 1] = 1'b1;
      if (pk_drop[id]) begin
        last_g = a + s;
        e_under[a + s + 1] = 1'b1;
        nxt = a + s + GAP + 2;
      end else begin
        last_g = a + s - 1;
        nxt = a + s + GAP + 1;
      end
      for (int c = a; c <= last_g; c++) e_grant[c] = NP'(1) << w;
      for (int c = a; c <= nxt - 2; c++) e_busy[c] = 1'b1;
      m_ptr = (w + 1) % NP;
      a = nxt;
    end
    m_free = a;
  endtask

  task automatic drive();
    int id;
    for (int p = 0; p < NP; p++) begin
      if (hold[p]) begin
        in_valid[p] = 1'b0;
        hold[p] = 1'b0;
      end else if (port_q[p].size() > 0) begin
        id = port_q[p][0];
        in_valid[p] = 1'b1;
        in_data[p*DW +: DW] = beat_store[pk_base[id] + bidx[p]];
      end else begin
        in_valid[p] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    bit xf[NP];
    int id;
    @(negedge clk);
    for (int p = 0; p < NP; p++) xf[p] = in_valid[p] && in_ready[p];
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (xf[p] && port_q[p].size() > 0) begin
        id = port_q[p][0];
        bidx[p]++;
        if (bidx[p] == pk_supply[id]) begin
          void'(port_q[p].pop_front());
          bidx[p] = 0;
          if (pk_drop[id]) hold[p] = 1'b1;
        end
      end
    end
    drive();
  endtask

  task automatic clear_sources();
    for (int p = 0; p < NP; p++) begin
      port_q[p].delete();
      m_pend[p].delete();
      bidx[p] = 0;
      hold[p] = 1'b0;
    end
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_sources();
    tick();
    tick();
    reset = 1'b0;
    m_ptr = 0;
    m_free = 0;
  endtask

  task automatic drain();
    int t = 0;
    bool_loop: while ((exp_q.size() > 0 || pend_q_any() || cyc < m_free + 1) && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
    end
  endtask

  function automatic bit pend_q_any();
    bit r = 1'b0;
    for (int p = 0; p < NP; p++) if (port_q[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  // Monitor: per-cycle control comparison plus scoreboard pop on every valid beat.
  initial begin
    logic [NP-1:0] eg;
    bit eb, et, eu;
    beat_exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        eg = e_grant.exists(cyc) ? e_grant[cyc] : '0;
        eb = e_busy.exists(cyc)  ? e_busy[cyc]  : 1'b0;
        et = e_trunc.exists(cyc) ? e_trunc[cyc] : 1'b0;
        eu = e_under.exists(cyc) ? e_under[cyc] : 1'b0;
        n_tests++;
        if ({busy, grant, in_ready, truncated, underrun} !== {eb, eg, eg, et, eu}) begin
          n_fail++;
          $display("FAIL ctrl cyc=%0d: got busy=%b grant=%b in_ready=%b trunc=%b under=%b expected busy=%b grant=%b in_ready=%b trunc=%b under=%b",
                   cyc, busy, grant, in_ready, truncated, underrun, eb, eg, eg, et, eu);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_missing: got no beat at cyc=%0d expected beat %h", exp_q[0].cyc, exp_q[0].data[63:0]);
          void'(exp_q.pop_front());
        end
        if (valid) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_extra cyc=%0d: got dout=%h expected no beat", cyc, dout[63:0]);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.data !== dout) begin
              n_fail++;
              $display("FAIL beat cyc=%0d: got dout=%h expected cyc=%0d dout=%h", cyc, dout[63:0], e.cyc, e.data[63:0]);
            end else begin
              $display("[TB] beat cyc=%0d grant=%b plen_field=%0d dout=%h", cyc, grant, dout[479:464], dout[63:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np_pkts, drop_k;
    logic [15:0] plen;
    in_valid = '0;
    in_data  = '0;
    reset    = 1'b1;
    for (int p = 0; p < NP; p++) begin
      bidx[p] = 0;
      hold[p] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",    64'(valid),     64'd0);
    chk("rst_grant",    64'(grant),     64'd0);
    chk("rst_in_ready", 64'(in_ready),  64'd0);
    chk("rst_busy",     64'(busy),      64'd0);
    chk("rst_pulses",   64'({underrun, truncated}), 64'd0);
    chk_w("rst_dout", dout, '0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Three-beat packet, then dout must hold its last beat.
    add_pkt(0, 16'd192, 0);
    run_model();
    drain();
    chk_w("dout_hold", dout, beat_store[beat_store.size() - 1]);

    // All ports contending with single-beat packets.
    do_reset();
    for (int p = 0; p < NP; p++) add_pkt(p, 16'd64, 0);
    add_pkt(0, 16'd64, 0);
    run_model();
    drain();

    // Zero-length packet, then a 2-vs-3 tie resolved by the pointer.
    do_reset();
    add_pkt(2, 16'd0, 0);
    add_pkt(2, 16'd64, 0);
    add_pkt(3, 16'd64, 0);
    run_model();
    drain();

    // Oversized packet truncated to MAXB beats.
    add_pkt(1, 16'd4096, 0);
    add_pkt(1, 16'd64, 0);
    run_model();
    drain();

    // Source drops valid after two beats of four, then sends a fresh packet.
    add_pkt(0, 16'd256, 2);
    add_pkt(0, 16'd128, 0);
    run_model();
    drain();

    // Reset lands on the third beat of a five-beat packet.
    mon_en = 1'b0;
    add_pkt(2, 16'd320, 0);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_valid",    64'(valid),    64'd0);
    chk("mid_rst_grant",    64'(grant),    64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_busy",     64'(busy),     64'd0);
    chk_w("mid_rst_dout", dout, '0);
    clear_sources();
    reset  = 1'b0;
    m_ptr  = 0;
    m_free = 0;
    tick();
    mon_en = 1'b1;
    for (int p = NP - 1; p >= 0; p--) add_pkt(p, 16'd64, 0);
    run_model();
    drain();

    // Randomised rounds.
    for (int r = 0; r < 25; r++) begin
      for (int p = 0; p < NP; p++) begin
        np_pkts = $urandom_range(0, 2);
        for (int k = 0; k < np_pkts; k++) begin
          case ($urandom_range(0, 5))
            0:       plen = 16'd0;
            1:       plen = 16'($urandom_range(1, 64));
            2:       plen = 16'($urandom_range(65, 1024));
            3:       plen = 16'($urandom_range(1500, 4096));
            default: plen = 16'($urandom_range(1, 512));
          endcase
          drop_k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
          add_pkt(p, plen, drop_k);
        end
      end
      run_model();
      drain();
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
